// File: rtl/stack_pkg.sv
// Shared constants and accept rules for the parameterised LIFO/FIFO operand buffer.
package stack_pkg;

   localparam int MODE_LIFO = 0;
   localparam int MODE_FIFO = 1;

   typedef struct packed {
      logic push_ok;
      logic pop_ok;
      logic ovf;
      logic unf;
   } accept_t;

   // A push into a full buffer is still taken when the same-cycle pop frees the head slot.
   function automatic accept_t stack_accept(input logic push, input logic pop,
                                            input logic full, input logic empty);
      accept_t a;
      a.pop_ok  = pop & ~empty;
      a.push_ok = push & (~full | a.pop_ok);
      a.ovf     = push & ~a.push_ok;
      a.unf     = pop & ~a.pop_ok;
      return a;
   endfunction

endpackage

// File: rtl/stack_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port, never reset.
module stack_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack_buf.sv
// Parameterised operand buffer: LIFO stack or FIFO queue with status and error pulses.
module stack_buf
   import stack_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 2,
   parameter int MODE       = MODE_LIFO
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  en,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      data_in,
   output logic [WIDTH-1:0]      data_out,
   output logic [WIDTH-1:0]      peek,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  ovf,
   output logic                  unf
);

   localparam int N  = 1 << DEPTH_LOG2;
   localparam int AW = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
   localparam int CW = DEPTH_LOG2 + 1;

   logic [CW-1:0]    count_q, count_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             full_w, empty_w;
   accept_t          acc;
   logic [AW-1:0]    top_idx, waddr, raddr;
   logic             we;
   logic [WIDTH-1:0] head;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(N - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full_w  = (count_q == CW'(N));
   assign empty_w = (count_q == '0);

   // Gating the strobes with en makes a disabled cycle look like an idle one.
   assign acc     = stack_accept(push & en, pop & en, full_w, empty_w);
   assign top_idx = AW'(count_q - CW'(1));
   assign we      = acc.push_ok;

   always_comb begin
      if (MODE == MODE_FIFO) begin
         waddr = wptr_q;
         raddr = rptr_q;
      end else begin
         raddr = top_idx;
         waddr = acc.pop_ok ? top_idx : AW'(count_q);
      end
   end

   always_comb begin
      count_d = count_q;
      case ({acc.push_ok, acc.pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      rptr_d     = (MODE == MODE_FIFO && acc.pop_ok)  ? ptr_inc(rptr_q) : rptr_q;
      wptr_d     = (MODE == MODE_FIFO && acc.push_ok) ? ptr_inc(wptr_q) : wptr_q;
      data_out_d = acc.pop_ok ? head : data_out_q;
      ovf_d      = acc.ovf;
      unf_d      = acc.unf;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         count_q    <= '0;
         rptr_q     <= '0;
         wptr_q     <= '0;
         data_out_q <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         count_q    <= count_d;
         rptr_q     <= rptr_d;
         wptr_q     <= wptr_d;
         data_out_q <= data_out_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   stack_ram #(
      .WIDTH (WIDTH),
      .DEPTH (N),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (data_in),
      .raddr (raddr),
      .rdata (head)
   );

   // Stale storage is never exposed once the buffer is empty.
   assign peek     = empty_w ? '0 : head;
   assign data_out = data_out_q;
   assign count    = count_q;
   assign full     = full_w;
   assign empty    = empty_w;
   assign ovf      = ovf_q;
   assign unf      = unf_q;

endmodule

// File: tb/tb_stack_buf.sv
// Bench for stack_buf: LIFO and FIFO instances share stimulus, checked against queue models.
module tb_stack_buf;

   localparam int N = 4;

   logic       clk, clr, en, push, pop;
   logic [7:0] din;

   logic [7:0] lo_dout, lo_peek, fo_dout, fo_peek;
   logic [2:0] lo_count, fo_count;
   logic       lo_full, lo_empty, lo_ovf, lo_unf;
   logic       fo_full, fo_empty, fo_ovf, fo_unf;

   int npass = 0;
   int ntot  = 0;
   bit chk_on = 0;

   stack_buf #(.WIDTH(8), .DEPTH_LOG2(2), .MODE(0)) u_lifo (
      .clk(clk), .clr(clr), .en(en), .push(push), .pop(pop), .data_in(din),
      .data_out(lo_dout), .peek(lo_peek), .count(lo_count), .full(lo_full),
      .empty(lo_empty), .ovf(lo_ovf), .unf(lo_unf));

   stack_buf #(.WIDTH(8), .DEPTH_LOG2(2), .MODE(1)) u_fifo (
      .clk(clk), .clr(clr), .en(en), .push(push), .pop(pop), .data_in(din),
      .data_out(fo_dout), .peek(fo_peek), .count(fo_count), .full(fo_full),
      .empty(fo_empty), .ovf(fo_ovf), .unf(fo_unf));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      ntot++;
      if (act == exp) npass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
   endtask

   // Behavioural model: the stack is a queue popped from the back, the FIFO from the front.
   logic [7:0] ql[$];
   logic [7:0] qf[$];
   logic [7:0] m_lo_dout, m_fo_dout;
   logic       m_lo_ovf, m_lo_unf, m_fo_ovf, m_fo_unf;

   task automatic model_step();
      if (clr) begin
         ql.delete(); qf.delete();
         m_lo_dout = 0; m_fo_dout = 0;
         m_lo_ovf = 0; m_lo_unf = 0; m_fo_ovf = 0; m_fo_unf = 0;
         return;
      end
      m_lo_ovf = 0; m_lo_unf = 0; m_fo_ovf = 0; m_fo_unf = 0;
      if (!en) return;
      if (push && pop) begin
         if (ql.size() == 0) begin ql.push_back(din); m_lo_unf = 1; end
         else begin m_lo_dout = ql.pop_back(); ql.push_back(din); end
         if (qf.size() == 0) begin qf.push_back(din); m_fo_unf = 1; end
         else begin m_fo_dout = qf.pop_front(); qf.push_back(din); end
      end else if (push) begin
         if (ql.size() == N) m_lo_ovf = 1; else ql.push_back(din);
         if (qf.size() == N) m_fo_ovf = 1; else qf.push_back(din);
      end else if (pop) begin
         if (ql.size() == 0) m_lo_unf = 1; else m_lo_dout = ql.pop_back();
         if (qf.size() == 0) m_fo_unf = 1; else m_fo_dout = qf.pop_front();
      end
   endtask

   always @(posedge clk or posedge clr) model_step();

   always @(negedge clk) begin
      if (chk_on) begin
         chk("lifo.count", lo_count, ql.size());
         chk("lifo.peek",  lo_peek,  ql.size() > 0 ? ql[ql.size()-1] : 0);
         chk("lifo.dout",  lo_dout,  m_lo_dout);
         chk("lifo.full",  lo_full,  ql.size() == N);
         chk("lifo.empty", lo_empty, ql.size() == 0);
         chk("lifo.ovf",   lo_ovf,   m_lo_ovf);
         chk("lifo.unf",   lo_unf,   m_lo_unf);
         chk("fifo.count", fo_count, qf.size());
         chk("fifo.peek",  fo_peek,  qf.size() > 0 ? qf[0] : 0);
         chk("fifo.dout",  fo_dout,  m_fo_dout);
         chk("fifo.full",  fo_full,  qf.size() == N);
         chk("fifo.empty", fo_empty, qf.size() == 0);
         chk("fifo.ovf",   fo_ovf,   m_fo_ovf);
         chk("fifo.unf",   fo_unf,   m_fo_unf);
      end
   end

   task automatic step(input logic ps, input logic pp, input logic [7:0] d);
      push = ps; pop = pp; din = d;
      @(posedge clk); #1;
      push = 0; pop = 0;
   endtask

   task automatic do_clr();
      clr = 1;
      @(posedge clk); #1;
      clr = 0;
   endtask

   initial begin
      clr = 1; en = 1; push = 0; pop = 0; din = 0;
      #2;
      @(posedge clk); #1;
      clr = 0;
      chk_on = 1;
      chk("rst.count", lo_count, 0);
      chk("rst.dout",  lo_dout, 0);
      chk("rst.empty", lo_empty, 1);
      chk("rst.peek",  fo_peek, 0);
      chk("rst.ovf",   fo_ovf, 0);

      // LIFO fill, overflow, drain
      step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33); step(1, 0, 8'h44);
      chk("t1.full", lo_full, 1);
      chk("t1.count", lo_count, 4);
      step(1, 0, 8'h55);
      chk("t1.ovf", lo_ovf, 1);
      chk("t1.peek", lo_peek, 8'h44);
      chk("t1.count5", lo_count, 4);
      step(0, 0, 8'h00);
      chk("t1.ovf_once", lo_ovf, 0);
      step(0, 1, 8'h00); chk("t1.pop1", lo_dout, 8'h44);
      step(0, 1, 8'h00); chk("t1.pop2", lo_dout, 8'h33);
      step(0, 1, 8'h00); chk("t1.pop3", lo_dout, 8'h22);
      step(0, 1, 8'h00); chk("t1.pop4", lo_dout, 8'h11);
      chk("t1.empty", lo_empty, 1);

      // Underflow and push+pop on empty
      step(0, 1, 8'h00);
      chk("t2.unf", lo_unf, 1);
      chk("t2.dout_hold", lo_dout, 8'h11);
      chk("t2.count", lo_count, 0);
      step(0, 0, 8'h00);
      chk("t2.unf_once", lo_unf, 0);
      step(1, 1, 8'h5A);
      chk("t2.pp_count", lo_count, 1);
      chk("t2.pp_peek", lo_peek, 8'h5A);
      chk("t2.pp_unf", lo_unf, 1);
      chk("t2.fifo_hold", fo_dout, 8'h44);

      // Push+pop while full
      do_clr();
      step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33); step(1, 0, 8'h44);
      step(1, 1, 8'h99);
      chk("t3.dout", lo_dout, 8'h44);
      chk("t3.count", lo_count, 4);
      chk("t3.peek", lo_peek, 8'h99);
      chk("t3.ovf", lo_ovf, 0);
      chk("t3.unf", lo_unf, 0);
      chk("t3.fifo_dout", fo_dout, 8'h11);

      // FIFO ordering across pointer wrap
      do_clr();
      for (int i = 1; i <= 4; i++) step(1, 0, 8'(i));
      step(0, 1, 8'h00); chk("t4.pop1", fo_dout, 8'h01);
      step(0, 1, 8'h00); chk("t4.pop2", fo_dout, 8'h02);
      step(1, 0, 8'h05); step(1, 0, 8'h06);
      chk("t4.full", fo_full, 1);
      chk("t4.peek", fo_peek, 8'h03);
      step(0, 1, 8'h00); chk("t4.pop3", fo_dout, 8'h03);
      step(0, 1, 8'h00); chk("t4.pop4", fo_dout, 8'h04);
      step(0, 1, 8'h00); chk("t4.pop5", fo_dout, 8'h05);
      step(0, 1, 8'h00); chk("t4.pop6", fo_dout, 8'h06);
      chk("t4.empty", fo_empty, 1);

      // Asynchronous clear in the middle of a cycle
      step(1, 0, 8'h21); step(1, 0, 8'h22);
      chk("t5.count_pre", fo_count, 2);
      #2 clr = 1;
      #1;
      chk("t5.count", fo_count, 0);
      chk("t5.dout", fo_dout, 0);
      chk("t5.peek", fo_peek, 0);
      clr = 0;
      step(1, 0, 8'h7E);
      chk("t5.peek_after", fo_peek, 8'h7E);
      chk("t5.count_after", fo_count, 1);

      // Disabled cycles hold state
      en = 0;
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 8'hAA);
         chk("t6.count", fo_count, 1);
         chk("t6.peek", fo_peek, 8'h7E);
         chk("t6.dout", fo_dout, 8'h00);
         chk("t6.ovf", fo_ovf, 0);
         chk("t6.unf", fo_unf, 0);
      end
      en = 1;
      step(0, 0, 8'h00);
      step(0, 0, 8'h00);

      chk_on = 0;
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
